vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 H_ACTIVE, 640, visible pixels per line
 H_FP, 16, horizontal front porch
 H_SYNC, 96, hsync width
 H_BP, 48, horizontal back porch (line total 800)
 V_ACTIVE, 480, visible lines
 V_FP, 10, vertical front porch
 V_SYNC, 2, vsync width
 V_BP, 33, vertical back porch (frame total 525)
REQ-002 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  pixel clock (25 MHz nominal); single clock domain
 rst_n  in  1  asynchronous active-low reset
 pixel_in  in  12  RGB444 from the frame buffer read port ([11:8]=R, [7:4]=G, [3:0]=B)
 test_pattern  in  1  1 = colour bars instead of the frame buffer
 row_read  out  8  frame buffer read row, 0..239
 col_read  out  9  frame buffer read column, 0..319
 vga_hsync  out  1  horizontal sync, active low
 vga_vsync  out  1  vertical sync, active low
 vga_r, vga_g, vga_b  out  4 each  pixel colour
 frame_start  out  1  one-cycle pulse aligned with the first visible pixel of a frame
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk and rst_n.

Function
REQ-004 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment only when h_cnt wraps and SHALL wrap 524->0.
REQ-005 active SHALL be (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-006 col_read SHALL be h_cnt[9:1] and row_read v_cnt[8:1] while active, else 0; both combinational from the counter registers (2x pixel doubling of a 320x240 buffer).
REQ-007 pixel_in SHALL be treated as valid in the same cycle as its address (asynchronous-read buffer).
REQ-008 RGB, hsync, vsync and frame_start SHALL be registered; all outputs share one cycle latency relative to the counters.
REQ-009 hsync SHALL be low for h_cnt 656..751 and vsync low for v_cnt 490..491 (before the register stage).
REQ-010 When not active, the registered RGB SHALL be 0.
REQ-011 Colour bars: bar = h_cnt/80 (0..7); R = {4{bar[2]}}, G = {4{bar[1]}}, B = {4{bar[0]}}.
REQ-012 test_pattern SHALL be sampled only when h_cnt=0 and v_cnt=0; a change mid-frame SHALL take effect at the next frame.
REQ-013 frame_start SHALL be 1 for exactly the one output cycle that carries pixel (0,0); otherwise it is 0.
REQ-014 The bit widths SHALL be h_cnt 10 bits and v_cnt 10 bits; no arithmetic overflow is permitted at wrap.

Reset
REQ-015 While rst_n=0: h_cnt=0, v_cnt=0, row_read=0, col_read=0, RGB=0, vga_hsync=1, vga_vsync=1, frame_start=0, latched test_pattern=0.
REQ-016 Reset assertion mid-line SHALL take effect immediately, without waiting for a clock edge.
REQ-017 After release, the first rising edge SHALL output pixel (0,0) with frame_start=1.

Structure
REQ-018 Timing constants and derived totals (H_TOTAL, V_TOTAL, sync start/end) SHALL live in a shared package vga_timing_pkg.
REQ-019 The counters and raw sync generation SHALL form one sub-module, vga_timing_gen; vga_scan_ctrl adds addressing, pattern mux and output registers.

Verification
REQ-020 Release reset with pixel_in=12'hCBD, test_pattern=0 -> first edge: frame_start=1, vga_r=C, vga_g=B, vga_b=D, row_read=0, col_read=0.
REQ-021 Run one line -> col_read steps 0,0,1,1,...,319,319, then is 0 for h_cnt 640..799; vga_hsync low for exactly 96 cycles, starting 657 cycles after the line start (registered).
REQ-022 Run one full frame -> 420000 cycles between frame_start pulses; vga_vsync low for 1600 cycles; row_read reaches 239 and never exceeds it.
REQ-023 Raise test_pattern at v_cnt=100 -> the current frame keeps showing pixel_in; the next frame shows output at h=0 of 000 and at h=80 of 00F, with output at h=560 of FFF.
REQ-024 Assert rst_n=0 at h_cnt=300, v_cnt=200 -> outputs reach reset values asynchronously; after release, the timing restarts at (0,0).
REQ-025 Drive pixel_in=12'hFFF during blanking -> RGB stays 0 throughout the blanking intervals.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, derived totals and small helpers for the scan controller.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int span_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int H_TOTAL      = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int V_TOTAL      = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
   localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   localparam int BAR_WIDTH = 80;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters with raw (unregistered) sync and active-area flags.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       active,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       origin
);

   localparam logic [9:0] H_LAST  = 10'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [9:0] V_LAST  = 10'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FROM = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_TO   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_FROM = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_TO   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Wrap is by explicit compare against the last count, so the counters never overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign hsync_raw = !((h_cnt >= HS_FROM) && (h_cnt < HS_TO));
   assign vsync_raw = !((v_cnt >= VS_FROM) && (v_cnt < VS_TO));
   assign origin    = (h_cnt == 10'd0) && (v_cnt == 10'd0);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: 2x-doubled frame buffer addressing, colour-bar mux and registered outputs.
module vga_scan_ctrl
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] pixel_in,
   input  logic        test_pattern,
   output logic [7:0]  row_read,
   output logic [8:0]  col_read,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       active;
   logic       hsync_raw;
   logic       vsync_raw;
   logic       origin;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk       (clk),
      .rst_n     (rst_n),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .active    (active),
      .hsync_raw (hsync_raw),
      .vsync_raw (vsync_raw),
      .origin    (origin)
   );

   logic       pattern_q;
   logic       pattern_sel;
   logic [2:0] bar;
   rgb_t       bar_rgb;
   rgb_t       pix_next;
   rgb_t       rgb_q;
   logic       hsync_q;
   logic       vsync_q;
   logic       frame_start_q;

   assign col_read = active ? 9'(h_cnt >> 1) : '0;
   assign row_read = active ? 8'(v_cnt >> 1) : '0;

   // The origin pixel already belongs to the new frame, so it uses the live input.
   assign pattern_sel = origin ? test_pattern : pattern_q;
   assign bar         = 3'(h_cnt / 10'(BAR_WIDTH));
   assign bar_rgb     = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};

   always_comb begin
      pix_next = '0;
      if (active) pix_next = pattern_sel ? bar_rgb : rgb_t'(pixel_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q     <= 1'b0;
         rgb_q         <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         if (origin) pattern_q <= test_pattern;
         rgb_q         <= pix_next;
         hsync_q       <= hsync_raw;
         vsync_q       <= vsync_raw;
         frame_start_q <= origin;
      end
   end

   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl with full-width lines and a shortened frame height.
module tb_vga_scan_ctrl;

   localparam int HA = 640, HF = 16, HS = 96, HB = 48;
   localparam int VA = 8,   VF = 2,  VS = 2,  VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] pixel_in = 12'h000;
   logic        test_pattern = 1'b0;
   logic [7:0]  row_read;
   logic [8:0]  col_read;
   logic        vga_hsync, vga_vsync, frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;

   vga_scan_ctrl #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pixel_in     (pixel_in),
      .test_pattern (test_pattern),
      .row_read     (row_read),
      .col_read     (col_read),
      .vga_hsync    (vga_hsync),
      .vga_vsync    (vga_vsync),
      .vga_r        (vga_r),
      .vga_g        (vga_g),
      .vga_b        (vga_b),
      .frame_start  (frame_start)
   );

   always #20 clk = ~clk;

   int   n_checks = 0;
   int   n_fail = 0;
   int   k = 0;
   logic model_pat = 1'b0;

   typedef struct {
      int          edge_n;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [8:0]  col;
      logic [7:0]  row;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      model_pat = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   function automatic logic [11:0] bars(input int h);
      int b;
      b = h / 80;
      return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
   endfunction

   // Output after edge k shows scan position k-1; the counters then sit at position k.
   task automatic model_check();
      int p, h, v, q, hn, vn;
      logic act;
      logic [11:0] e_rgb;
      p  = (k - 1) % FR;
      h  = p % HT;
      v  = p / HT;
      q  = k % FR;
      hn = q % HT;
      vn = q / HT;
      if (p == 0) model_pat = test_pattern;
      act   = (h < HA) && (v < VA);
      e_rgb = !act ? 12'h000 : (model_pat ? bars(h) : pixel_in);
      chk("m_rgb", {vga_r, vga_g, vga_b}, e_rgb);
      chk("m_hsync", vga_hsync, !(h >= HA + HF && h < HA + HF + HS));
      chk("m_vsync", vga_vsync, !(v >= VA + VF && v < VA + VF + VS));
      chk("m_frame_start", frame_start, p == 0);
      chk("m_col", col_read, (hn < HA && vn < VA) ? hn / 2 : 0);
      chk("m_row", row_read, (hn < HA && vn < VA) ? vn / 2 : 0);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < FR * 2 && k < target; i++) step();
   endtask

   initial begin
      int last_fs, vs_low, n_fs, row_max;

      tbl.push_back(vec_t'{1,     12'hCBD, 1'b1, 1'b1, 1'b1, 9'd0,   8'd0});
      tbl.push_back(vec_t'{2,     12'hCBD, 1'b1, 1'b1, 1'b0, 9'd1,   8'd0});
      tbl.push_back(vec_t'{3,     12'hCBD, 1'b1, 1'b1, 1'b0, 9'd1,   8'd0});
      tbl.push_back(vec_t'{4,     12'hCBD, 1'b1, 1'b1, 1'b0, 9'd2,   8'd0});
      tbl.push_back(vec_t'{639,   12'hCBD, 1'b1, 1'b1, 1'b0, 9'd319, 8'd0});
      tbl.push_back(vec_t'{640,   12'hCBD, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{641,   12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{656,   12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{657,   12'h000, 1'b0, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{752,   12'h000, 1'b0, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{753,   12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{800,   12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{1600,  12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd1});
      tbl.push_back(vec_t'{1601,  12'hCBD, 1'b1, 1'b1, 1'b0, 9'd0,   8'd1});
      tbl.push_back(vec_t'{6000,  12'hCBD, 1'b1, 1'b1, 1'b0, 9'd200, 8'd3});
      tbl.push_back(vec_t'{6401,  12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{8000,  12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{8001,  12'h000, 1'b1, 1'b0, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{9600,  12'h000, 1'b1, 1'b0, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{9601,  12'h000, 1'b1, 1'b1, 1'b0, 9'd0,   8'd0});
      tbl.push_back(vec_t'{11201, 12'hCBD, 1'b1, 1'b1, 1'b1, 9'd0,   8'd0});

      // Reset values while held in reset
      @(negedge clk);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      chk("rst_hsync", vga_hsync, 1'b1);
      chk("rst_vsync", vga_vsync, 1'b1);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_col", col_read, 9'd0);
      chk("rst_row", row_read, 8'd0);

      // Directed vectors over the first frame and the start of the second
      pixel_in = 12'hCBD;
      test_pattern = 1'b0;
      do_reset();
      foreach (tbl[i]) begin
         run_to(tbl[i].edge_n);
         chk("t_rgb", {vga_r, vga_g, vga_b}, tbl[i].rgb);
         chk("t_hsync", vga_hsync, tbl[i].hs);
         chk("t_vsync", vga_vsync, tbl[i].vs);
         chk("t_frame_start", frame_start, tbl[i].fs);
         chk("t_col", col_read, tbl[i].col);
         chk("t_row", row_read, tbl[i].row);
      end

      // Asynchronous reset in the middle of line 5, column 300
      do_reset();
      run_to(5 * HT + 300);
      chk("pre_async_col", col_read, 9'd150);
      rst_n = 1'b0;
      #1;
      chk("async_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      chk("async_col", col_read, 9'd0);
      chk("async_row", row_read, 8'd0);
      chk("async_hsync", vga_hsync, 1'b1);
      chk("async_vsync", vga_vsync, 1'b1);
      chk("async_frame_start", frame_start, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      step();
      chk("restart_frame_start", frame_start, 1'b1);
      chk("restart_rgb", {vga_r, vga_g, vga_b}, 12'hCBD);
      chk("restart_col", col_read, 9'd0);

      // Test pattern raised mid-frame only applies from the next frame
      do_reset();
      run_to(5 * HT + 1);
      test_pattern = 1'b1;
      run_to(6 * HT + 1);
      chk("tp_same_frame", {vga_r, vga_g, vga_b}, 12'hCBD);
      run_to(FR + 1);
      chk("tp_next_h0", {vga_r, vga_g, vga_b}, 12'h000);
      chk("tp_next_fs", frame_start, 1'b1);
      run_to(FR + 81);
      chk("tp_next_h80", {vga_r, vga_g, vga_b}, 12'h00F);
      run_to(FR + 561);
      chk("tp_next_h560", {vga_r, vga_g, vga_b}, 12'hFFF);

      // Randomised pixels over three frames against the position model
      test_pattern = 1'b0;
      pixel_in = 12'($urandom);
      do_reset();
      last_fs = 0;
      vs_low = 0;
      n_fs = 0;
      row_max = 0;
      for (int i = 0; i < 3 * FR + 1; i++) begin
         step();
         model_check();
         if (frame_start) begin
            n_fs++;
            if (last_fs > 0) begin
               chk("fs_period", k - last_fs, FR);
               chk("vsync_low_cycles", vs_low, VS * HT);
            end
            last_fs = k;
            vs_low = 0;
         end
         if (!vga_vsync) vs_low++;
         if (int'(row_read) > row_max) row_max = int'(row_read);
         pixel_in = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
         if (k == FR / 2) test_pattern = 1'b1;
         if (k == FR + FR / 2) test_pattern = 1'b0;
      end
      chk("fs_pulses", n_fs, 4);
      chk("row_max", row_max, (VA - 1) / 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
